l1_mem_arbiter: RTL and testbench

//  Shares one downstream memory/L2 port between the Icache (read-only line fill) and the Dcache
//  (line read on miss, word write-through on store). Supports one outstanding transaction.

---
 rtl/l1_mem_arbiter_if.sv | 30 +++
 rtl/l1_mem_arbiter.sv | 125 ++++++++++++
 tb/tb_l1_mem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l1_mem_arbiter_if.sv
// Cache-side and memory-side handshake bundles for the L1 memory arbiter.
// l1_rd_if carries a read-only line fill; l1_mem_if adds write fields and bvalid.
interface l1_rd_if #(parameter int LINE_W = 128);
    logic              req;
    logic [31:0]       addr;
    logic              addr_ok;
    logic              data_ok;
    logic [LINE_W-1:0] rdata;

    modport master (output req, addr, input addr_ok, data_ok, rdata);
    modport slave  (input req, addr, output addr_ok, data_ok, rdata);
endinterface

interface l1_mem_if #(parameter int LINE_W = 128);
    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic [3:0]        wstrb;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic              addr_ok;
    logic              data_ok;
    logic              bvalid;
    logic [LINE_W-1:0] rdata;

    modport master (output req, wr, size, wstrb, addr, wdata,
                    input  addr_ok, data_ok, bvalid, rdata);
    modport slave  (input  req, wr, size, wstrb, addr, wdata,
                    output addr_ok, data_ok, bvalid, rdata);
endinterface

// File: rtl/l1_mem_arbiter.sv
// Shares one downstream memory port between Icache line fills and Dcache reads/writes,
// one outstanding transaction, alternating priority on ties.
//
// state | meaning
// IDLE  | no grant; pick next requester (tie goes to the one not served last)
// A_I   | Icache granted, address phase
// D_I   | Icache waiting for read data
// A_D   | Dcache granted, address phase (request fields passed straight through)
// D_D   | Dcache waiting for read data
// W_D   | Dcache write waiting for bvalid (only reachable when WAIT_BVALID=1)
module l1_mem_arbiter #(
    parameter int LINE_W      = 128,
    parameter bit WAIT_BVALID = 1'b0
) (
    input  logic       clk,
    input  logic       rstn,
    l1_rd_if.slave     icache,
    l1_mem_if.slave    dcache,
    l1_mem_if.master   mem
);
    typedef enum logic [2:0] {IDLE, A_I, D_I, A_D, D_D, W_D} state_t;

    localparam logic              SRC_I     = 1'b0;
    localparam logic              SRC_D     = 1'b1;
    localparam logic [LINE_W-1:0] ZERO_LINE = '0;

    state_t state, state_nxt;
    logic   last, last_nxt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            last  <= SRC_I;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        last_nxt       = last;
        mem.req        = 1'b0;
        mem.wr         = 1'b0;
        mem.size       = 2'd0;
        mem.wstrb      = 4'd0;
        mem.addr       = 32'd0;
        mem.wdata      = 32'd0;
        icache.addr_ok = 1'b0;
        icache.data_ok = 1'b0;
        dcache.addr_ok = 1'b0;
        dcache.data_ok = 1'b0;
        dcache.bvalid  = 1'b0;
        case (state)
            IDLE: begin
                if (icache.req && dcache.req)
                    state_nxt = (last == SRC_I) ? A_D : A_I;
                else if (dcache.req)
                    state_nxt = A_D;
                else if (icache.req)
                    state_nxt = A_I;
            end
            A_I: begin
                mem.req  = icache.req;
                mem.size = 2'd2;
                mem.addr = icache.addr;
                // A dropped request abandons the grant without touching priority
                if (!icache.req) begin
                    state_nxt = IDLE;
                end else if (mem.addr_ok) begin
                    icache.addr_ok = 1'b1;
                    state_nxt      = D_I;
                end
            end
            D_I: begin
                if (mem.data_ok) begin
                    icache.data_ok = 1'b1;
                    last_nxt       = SRC_I;
                    state_nxt      = IDLE;
                end
            end
            A_D: begin
                mem.req   = dcache.req;
                mem.wr    = dcache.wr;
                mem.size  = dcache.size;
                mem.wstrb = dcache.wstrb;
                mem.addr  = dcache.addr;
                mem.wdata = dcache.wdata;
                if (!dcache.req) begin
                    state_nxt = IDLE;
                end else if (mem.addr_ok) begin
                    dcache.addr_ok = 1'b1;
                    if (!dcache.wr) begin
                        state_nxt = D_D;
                    end else if (WAIT_BVALID) begin
                        state_nxt = W_D;
                    end else begin
                        last_nxt  = SRC_D;
                        state_nxt = IDLE;
                    end
                end
            end
            D_D: begin
                if (mem.data_ok) begin
                    dcache.data_ok = 1'b1;
                    last_nxt       = SRC_D;
                    state_nxt      = IDLE;
                end
            end
            W_D: begin
                if (mem.bvalid) begin
                    dcache.bvalid = 1'b1;
                    last_nxt      = SRC_D;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Read data is gated so the non-granted side never sees a stale line
    assign icache.rdata = icache.data_ok ? mem.rdata : ZERO_LINE;
    assign dcache.rdata = dcache.data_ok ? mem.rdata : ZERO_LINE;

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Scoreboard bench for l1_mem_arbiter: directed stimulus pushes expected handshake events,
// negedge monitors pop and compare whatever the two DUT instances present.
module tb_l1_mem_arbiter;
    localparam int LW = 128;

    localparam logic [5:0] F_REQ = 6'b100000;
    localparam logic [5:0] F_IA  = 6'b010000;
    localparam logic [5:0] F_ID  = 6'b001000;
    localparam logic [5:0] F_DA  = 6'b000100;
    localparam logic [5:0] F_DD  = 6'b000010;
    localparam logic [5:0] F_DB  = 6'b000001;

    typedef struct packed {
        logic [31:0]   cyc;
        logic [5:0]    flags;
        logic [31:0]   addr;
        logic          wr;
        logic [LW-1:0] rdata;
    } evt_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    evt_t q0[$];
    evt_t q1[$];

    l1_rd_if  #(.LINE_W(LW)) ic0 ();
    l1_mem_if #(.LINE_W(LW)) dc0 ();
    l1_mem_if #(.LINE_W(LW)) mm0 ();
    l1_rd_if  #(.LINE_W(LW)) ic1 ();
    l1_mem_if #(.LINE_W(LW)) dc1 ();
    l1_mem_if #(.LINE_W(LW)) mm1 ();

    l1_mem_arbiter #(.LINE_W(LW), .WAIT_BVALID(1'b0)) u0 (
        .clk(clk), .rstn(rstn), .icache(ic0), .dcache(dc0), .mem(mm0));
    l1_mem_arbiter #(.LINE_W(LW), .WAIT_BVALID(1'b1)) u1 (
        .clk(clk), .rstn(rstn), .icache(ic1), .dcache(dc1), .mem(mm1));

    task automatic go(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic ex_evt(input int d, input int c, input logic [5:0] f, input logic [31:0] a,
                          input logic w, input logic [LW-1:0] r);
        evt_t e;
        e.cyc = c; e.flags = f; e.addr = a; e.wr = w; e.rdata = r;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic ex_req(input int d, input int c, input logic [31:0] a, input logic w);
        ex_evt(d, c, F_REQ, a, w, '0);
    endtask

    task automatic score(input int d, input evt_t a);
        evt_t e;
        n_checks++;
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            n_fail++;
            $display("FAIL unexpected_evt dut%0d: got cyc=%0d flags=%b addr=%h, want no event",
                     d, a.cyc, a.flags, a.addr);
            return;
        end
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        if (a !== e) begin
            n_fail++;
            $display("FAIL evt dut%0d: got cyc=%0d flags=%b addr=%h wr=%b rdata=%h, want cyc=%0d flags=%b addr=%h wr=%b rdata=%h",
                     d, a.cyc, a.flags, a.addr, a.wr, a.rdata, e.cyc, e.flags, e.addr, e.wr, e.rdata);
        end
    endtask

    logic prev_req0 = 1'b0;
    logic prev_req1 = 1'b0;

    always @(negedge clk) begin : mon0
        evt_t a;
        a = '0;
        a.cyc   = cyc;
        a.flags = {mm0.req && !prev_req0, ic0.addr_ok, ic0.data_ok, dc0.addr_ok, dc0.data_ok, dc0.bvalid};
        if (a.flags[5]) begin a.addr = mm0.addr; a.wr = mm0.wr; end
        if (ic0.data_ok)      a.rdata = ic0.rdata;
        else if (dc0.data_ok) a.rdata = dc0.rdata;
        prev_req0 = mm0.req;
        if (a.flags != 6'd0) score(0, a);
    end

    always @(negedge clk) begin : mon1
        evt_t a;
        a = '0;
        a.cyc   = cyc;
        a.flags = {mm1.req && !prev_req1, ic1.addr_ok, ic1.data_ok, dc1.addr_ok, dc1.data_ok, dc1.bvalid};
        if (a.flags[5]) begin a.addr = mm1.addr; a.wr = mm1.wr; end
        if (ic1.data_ok)      a.rdata = ic1.rdata;
        else if (dc1.data_ok) a.rdata = dc1.rdata;
        prev_req1 = mm1.req;
        if (a.flags != 6'd0) score(1, a);
    end

    task automatic set_mm(input int d, input logic aok, input logic dok, input logic bv,
                          input logic [LW-1:0] r);
        if (d == 0) begin mm0.addr_ok = aok; mm0.data_ok = dok; mm0.bvalid = bv; mm0.rdata = r; end
        else        begin mm1.addr_ok = aok; mm1.data_ok = dok; mm1.bvalid = bv; mm1.rdata = r; end
    endtask

    task automatic set_ic(input int d, input logic rq, input logic [31:0] a);
        if (d == 0) begin ic0.req = rq; ic0.addr = a; end
        else        begin ic1.req = rq; ic1.addr = a; end
    endtask

    task automatic set_dc(input int d, input logic rq, input logic w, input logic [31:0] a,
                          input logic [31:0] wd);
        if (d == 0) begin
            dc0.req = rq; dc0.wr = w; dc0.size = 2'd2; dc0.wstrb = 4'hf; dc0.addr = a; dc0.wdata = wd;
        end else begin
            dc1.req = rq; dc1.wr = w; dc1.size = 2'd2; dc1.wstrb = 4'hf; dc1.addr = a; dc1.wdata = wd;
        end
    endtask

    // addrOK for one cycle at c; the requester drops its req the cycle after
    task automatic addr_hs(input int d, input int c, input bit dside, input logic [5:0] f);
        ex_evt(d, c, f, 32'd0, 1'b0, '0);
        go(c);
        set_mm(d, 1'b1, 1'b0, 1'b0, '0);
        go(c + 1);
        set_mm(d, 1'b0, 1'b0, 1'b0, '0);
        if (dside) set_dc(d, 1'b0, 1'b0, 32'd0, 32'd0);
        else       set_ic(d, 1'b0, 32'd0);
    endtask

    task automatic data_hs(input int d, input int c, input logic [5:0] f, input logic [LW-1:0] r);
        ex_evt(d, c, f, 32'd0, 1'b0, (f == F_DB) ? '0 : r);
        go(c);
        set_mm(d, 1'b0, (f != F_DB), (f == F_DB), r);
        go(c + 1);
        set_mm(d, 1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int b;
        set_ic(0, 1'b1, 32'h0); set_dc(0, 1'b1, 1'b0, 32'h0, 32'h0);
        set_ic(1, 1'b0, 32'h0); set_dc(1, 1'b0, 1'b0, 32'h0, 32'h0);
        set_mm(0, 1'b1, 1'b1, 1'b1, '1);
        set_mm(1, 1'b0, 1'b0, 1'b0, '0);
        rstn = 1'b0;
        go(2);
        chk("rst_arb_req",  LW'(mm0.req), '0);
        chk("rst_i_addrok", LW'(ic0.addr_ok), '0);
        chk("rst_d_dataok", LW'(dc0.data_ok), '0);
        chk("rst_d_bvalid", LW'(dc0.bvalid), '0);
        chk("rst_d_rdata",  dc0.rdata, '0);
        chk("rst_i_rdata",  ic0.rdata, '0);
        set_ic(0, 1'b0, 32'h0); set_dc(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_mm(0, 1'b0, 1'b0, 1'b0, '0);
        go(3);
        rstn = 1'b1;

        // Tie after reset: Dcache first, Icache after one IDLE cycle, next tie Dcache again
        go(5); b = cyc;
        set_ic(0, 1'b1, 32'h2000); set_dc(0, 1'b1, 1'b0, 32'h3000, 32'h0);
        ex_req(0, b + 1, 32'h3000, 1'b0);
        addr_hs(0, b + 2, 1'b1, F_DA);
        data_hs(0, b + 4, F_DD, 128'h0123_4567_89ab_cdef_0011_2233_4455_6677);
        chk("min_gap_idle", LW'(mm0.req), '0);
        ex_req(0, b + 6, 32'h2000, 1'b0);
        addr_hs(0, b + 7, 1'b0, F_IA);
        data_hs(0, b + 9, F_ID, 128'hfeed_0000_1111_2222_3333_4444_5555_6666);
        set_ic(0, 1'b1, 32'h2040); set_dc(0, 1'b1, 1'b0, 32'h3040, 32'h0);
        ex_req(0, b + 11, 32'h3040, 1'b0);
        addr_hs(0, b + 12, 1'b1, F_DA);
        data_hs(0, b + 14, F_DD, 128'h1);
        ex_req(0, b + 16, 32'h2040, 1'b0);
        addr_hs(0, b + 17, 1'b0, F_IA);
        data_hs(0, b + 19, F_ID, 128'h2);

        // Dcache write released at addrOK; pending Icache granted right after
        go(cyc + 1); b = cyc;
        set_dc(0, 1'b1, 1'b1, 32'h4000, 32'hdead_beef);
        ex_req(0, b + 1, 32'h4000, 1'b1);
        go(b + 1);
        chk("wr_wdata", LW'(mm0.wdata), LW'(32'hdead_beef));
        chk("wr_wstrb", LW'(mm0.wstrb), LW'(4'hf));
        set_ic(0, 1'b1, 32'h5000);
        go(b + 2);
        dc0.wdata = 32'h1234_5678;
        #1;
        chk("wr_wdata_live", LW'(mm0.wdata), LW'(32'h1234_5678));
        addr_hs(0, b + 2, 1'b1, F_DA);
        chk("wr_released", LW'(mm0.req), '0);
        ex_req(0, b + 4, 32'h5000, 1'b0);
        addr_hs(0, b + 5, 1'b0, F_IA);
        data_hs(0, b + 7, F_ID, 128'h3);

        // Dcache read alone
        go(cyc + 1); b = cyc;
        set_dc(0, 1'b1, 1'b0, 32'h1000, 32'h0);
        ex_req(0, b + 1, 32'h1000, 1'b0);
        go(b + 2);
        chk("rd_req_c2", LW'(mm0.req), LW'(1'b1));
        addr_hs(0, b + 3, 1'b1, F_DA);
        chk("rd_req_after_aok", LW'(mm0.req), '0);
        data_hs(0, b + 6, F_DD, 128'hcafe_f00d);

        // Stray handshakes in IDLE, then reset in the middle of a Dcache read
        go(cyc + 1); b = cyc;
        set_mm(0, 1'b1, 1'b1, 1'b1, 128'h77);
        go(b + 1);
        set_mm(0, 1'b0, 1'b0, 1'b0, '0);
        chk("stray_idle_req", LW'(mm0.req), '0);
        set_dc(0, 1'b1, 1'b0, 32'h7000, 32'h0);
        ex_req(0, b + 2, 32'h7000, 1'b0);
        addr_hs(0, b + 3, 1'b1, F_DA);
        go(b + 5);
        set_mm(0, 1'b0, 1'b1, 1'b0, 128'h88);
        rstn = 1'b0;
        #1;
        chk("rst_mid_dataok", LW'(dc0.data_ok), '0);
        chk("rst_mid_rdata",  dc0.rdata, '0);
        go(b + 6);
        rstn = 1'b1;
        set_mm(0, 1'b0, 1'b0, 1'b0, '0);
        set_ic(0, 1'b1, 32'h8000); set_dc(0, 1'b1, 1'b0, 32'h8100, 32'h0);
        ex_req(0, b + 7, 32'h8100, 1'b0);
        addr_hs(0, b + 8, 1'b1, F_DA);
        data_hs(0, b + 10, F_DD, 128'h99);

        // Icache abort before addrOK keeps last=DCACHE, so the next tie goes to Icache
        ex_req(0, b + 12, 32'h8000, 1'b0);
        go(b + 13);
        set_ic(0, 1'b0, 32'h0);
        #1;
        chk("abort_req_low", LW'(mm0.req), '0);
        go(b + 14);
        chk("abort_idle", LW'(mm0.req), '0);
        set_ic(0, 1'b1, 32'h9000); set_dc(0, 1'b1, 1'b0, 32'h9100, 32'h0);
        ex_req(0, b + 15, 32'h9000, 1'b0);
        addr_hs(0, b + 16, 1'b0, F_IA);
        set_dc(0, 1'b0, 1'b0, 32'h0, 32'h0);
        data_hs(0, b + 18, F_ID, 128'haa);

        // WAIT_BVALID=1 instance: write holds the port until bvalid
        go(cyc + 1); b = cyc;
        set_dc(1, 1'b1, 1'b1, 32'ha000, 32'h55aa_55aa);
        ex_req(1, b + 1, 32'ha000, 1'b1);
        go(b + 1);
        set_ic(1, 1'b1, 32'hb000);
        addr_hs(1, b + 2, 1'b1, F_DA);
        chk("wd_req_low", LW'(mm1.req), '0);
        go(b + 4);
        set_mm(1, 1'b0, 1'b1, 1'b0, 128'hbb);
        data_hs(1, b + 5, F_DB, '0);
        chk("wd_done_idle", LW'(mm1.req), '0);
        ex_req(1, b + 7, 32'hb000, 1'b0);
        addr_hs(1, b + 8, 1'b0, F_IA);
        data_hs(1, b + 10, F_ID, 128'hcc);

        go(cyc + 3);
        n_checks++;
        if (q0.size() != 0) begin
            n_fail++;
            $display("FAIL missing_evt dut0: got %0d pending, want 0", q0.size());
        end
        n_checks++;
        if (q1.size() != 0) begin
            n_fail++;
            $display("FAIL missing_evt dut1: got %0d pending, want 0", q1.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
